ide_cycle: RTL and testbench

Zorro II bus responder for the on-card IDE port and its autoboot ROM. It sits beside `autoconfig_zii`, decodes CPU cycles that hit the configured IDE base, and translates each one into ATA PIO-0 strobes or a ROM read. It terminates every claimed cycle with `DTACK_n`. Everything runs on `C7M`; CPU-side strobes are synchronised in, so cycle timing holds in both stock and turbo CPU modes.

---
 rtl/ide_pkg.sv | 39 +++
 rtl/ide_if.sv | 40 ++++
 rtl/ide_cycle_sync2.sv | 26 ++
 rtl/ide_cycle.sv | 171 +++++++++++++++++
 tb/tb_ide_cycle.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ide_pkg.sv
// Shared types and constants for the Zorro II IDE/boot-ROM cycle responder.
package ide_pkg;

    localparam int unsigned ADDR_HI_W  = 8;
    localparam int unsigned ADDR_MID_W = 5;
    localparam int unsigned ADDR_REG_W = 2;
    localparam int unsigned DA_W       = 3;
    localparam int unsigned CNT_W      = 8;

    // Bit positions within the CPU address; the low decode field starts at A9
    localparam int unsigned LOW_ADDR_BIT = 9;
    localparam int unsigned REGION_BIT   = 15;
    localparam int unsigned CS_SEL_BIT   = 12;
    localparam int unsigned REGION_IDX   = REGION_BIT - LOW_ADDR_BIT;
    localparam int unsigned CS_SEL_IDX   = CS_SEL_BIT - LOW_ADDR_BIT;

    localparam int unsigned DEF_STROBE_CYCLES = 2;
    localparam int unsigned DEF_IORDY_TIMEOUT = 16;
    localparam int unsigned DEF_ROM_WAIT      = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4,
        ROM    = 3'd5
    } state_t;

    // Cycle attributes latched when a claimed cycle starts
    typedef struct packed {
        logic            ata;
        logic            cs1;
        logic [DA_W-1:0] da;
        logic            rd;
        logic            rom_rd;
    } cyc_t;

endpackage

// File: rtl/ide_if.sv
// CPU-side and ATA/ROM-side signal bundle for ide_cycle.
interface ide_if;
    import ide_pkg::*;

    logic                  AS_CPU_n;
    logic                  DS_n;
    logic                  RW_n;
    logic [ADDR_HI_W-1:0]  A_HIGH;
    logic [ADDR_MID_W-1:0] A_MID;
    logic [ADDR_REG_W-1:0] A_REG;
    logic [ADDR_HI_W-1:0]  BASE_IDE;
    logic                  IDE_CONFIGURED_n;
    logic                  ROM_EN;
    logic                  IORDY;

    logic [1:0]            IDE_CS_n;
    logic [DA_W-1:0]       IDE_DA;
    logic                  IDE_RD_n;
    logic                  IDE_WR_n;
    logic                  IDE_BUF_OE_n;
    logic                  IDE_BUF_DIR;
    logic                  ROM_OE_n;
    logic                  DTACK_n;
    logic                  IDE_RST_n;

    modport slave (
        input  AS_CPU_n, DS_n, RW_n, A_HIGH, A_MID, A_REG, BASE_IDE,
               IDE_CONFIGURED_n, ROM_EN, IORDY,
        output IDE_CS_n, IDE_DA, IDE_RD_n, IDE_WR_n, IDE_BUF_OE_n,
               IDE_BUF_DIR, ROM_OE_n, DTACK_n, IDE_RST_n
    );

    modport master (
        output AS_CPU_n, DS_n, RW_n, A_HIGH, A_MID, A_REG, BASE_IDE,
               IDE_CONFIGURED_n, ROM_EN, IORDY,
        input  IDE_CS_n, IDE_DA, IDE_RD_n, IDE_WR_n, IDE_BUF_OE_n,
               IDE_BUF_DIR, ROM_OE_n, DTACK_n, IDE_RST_n
    );

endinterface

// File: rtl/ide_cycle_sync2.sv
// Two-flop synchroniser for a single asynchronous level; reset value selectable.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ide_cycle.sv
// Zorro II responder: decodes cycles at the IDE base and turns them into
// ATA PIO-0 strobes or boot-ROM reads, terminating each with DTACK_n.
module ide_cycle
    import ide_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned IORDY_TIMEOUT = DEF_IORDY_TIMEOUT,
    parameter int unsigned ROM_WAIT      = DEF_ROM_WAIT
) (
    input  logic  C7M,
    input  logic  RESET_n,
    ide_if.slave  bus
);

    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_MAX  = CNT_W'(STROBE_CYCLES - 1 + IORDY_TIMEOUT);
    localparam logic [CNT_W-1:0] ROM_LAST = CNT_W'(ROM_WAIT);

    logic w_as;
    logic w_ds;
    logic w_iordy;

    sync2 #(.RST_VAL(1'b1)) u_sync_as (
        .clk(C7M), .rst_n(RESET_n), .i_d(bus.AS_CPU_n), .o_q(w_as)
    );
    sync2 #(.RST_VAL(1'b1)) u_sync_ds (
        .clk(C7M), .rst_n(RESET_n), .i_d(bus.DS_n), .o_q(w_ds)
    );
    sync2 #(.RST_VAL(1'b1)) u_sync_iordy (
        .clk(C7M), .rst_n(RESET_n), .i_d(bus.IORDY), .o_q(w_iordy)
    );

    state_t                       r_state, w_state_nxt;
    logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
    cyc_t                         r_cyc, w_cyc_nxt, w_dec;
    logic [ADDR_MID_W+ADDR_REG_W-1:0] w_addr;
    logic                         w_hit;
    logic                         w_busy;

    logic [1:0]      r_cs_n,     w_cs_n_nxt;
    logic [DA_W-1:0] r_da,       w_da_nxt;
    logic            r_rd_n,     w_rd_n_nxt;
    logic            r_wr_n,     w_wr_n_nxt;
    logic            r_buf_oe_n, w_buf_oe_n_nxt;
    logic            r_buf_dir,  w_buf_dir_nxt;
    logic            r_rom_oe_n, w_rom_oe_n_nxt;
    logic            r_dtack_n,  w_dtack_n_nxt;
    logic            r_ide_rst_n;

    // Address decode of the current bus inputs (A[15:9])
    assign w_addr = {bus.A_MID, bus.A_REG};
    assign w_hit  = !bus.IDE_CONFIGURED_n && (bus.A_HIGH == bus.BASE_IDE);

    always_comb begin
        w_dec        = '0;
        w_dec.ata    = w_addr[REGION_IDX];
        w_dec.cs1    = w_addr[CS_SEL_IDX];
        w_dec.da     = w_addr[DA_W-1:0];
        w_dec.rd     = bus.RW_n;
        w_dec.rom_rd = !w_addr[REGION_IDX] && bus.RW_n && bus.ROM_EN;
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cyc_nxt     = r_cyc;
        w_buf_dir_nxt = r_buf_dir;

        case (r_state)
            IDLE: begin
                if (!w_as && !w_ds && w_hit) begin
                    w_cyc_nxt     = w_dec;
                    w_buf_dir_nxt = bus.RW_n;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = w_dec.ata ? SETUP : ROM;
                end
            end
            SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = STROBE;
            end
            STROBE: begin
                if ((r_cnt < STB_LAST) || (!w_iordy && (r_cnt < STB_MAX))) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: w_state_nxt = ACK;
            ACK: begin
                if (w_as) begin
                    w_state_nxt = IDLE;
                end
            end
            ROM: begin
                // First ROM cycle is address setup; OE follows for ROM_WAIT cycles
                if (r_cnt < ROM_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ACK;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if ((r_state != IDLE) && w_as) begin
            w_state_nxt = IDLE;
        end

        w_busy = w_cyc_nxt.ata &&
                 ((w_state_nxt == SETUP) || (w_state_nxt == STROBE) ||
                  (w_state_nxt == HOLD)  || (w_state_nxt == ACK));

        w_cs_n_nxt = 2'b11;
        w_da_nxt   = '0;
        if (w_busy) begin
            w_cs_n_nxt = w_cyc_nxt.cs1 ? 2'b01 : 2'b10;
            w_da_nxt   = w_cyc_nxt.da;
        end

        w_rd_n_nxt     = !((w_state_nxt == STROBE) &&  w_cyc_nxt.rd);
        w_wr_n_nxt     = !((w_state_nxt == STROBE) && !w_cyc_nxt.rd);
        w_buf_oe_n_nxt = !w_busy;
        w_rom_oe_n_nxt = !(w_cyc_nxt.rom_rd &&
                           (((w_state_nxt == ROM) && (w_cnt_nxt != '0)) ||
                            ((w_state_nxt == ACK) && !w_cyc_nxt.ata)));
        w_dtack_n_nxt  = !(w_state_nxt == ACK);
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cyc       <= '0;
            r_cs_n      <= 2'b11;
            r_da        <= '0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_buf_oe_n  <= 1'b1;
            r_buf_dir   <= 1'b0;
            r_rom_oe_n  <= 1'b1;
            r_dtack_n   <= 1'b1;
            r_ide_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cyc       <= w_cyc_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_da        <= w_da_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_buf_oe_n  <= w_buf_oe_n_nxt;
            r_buf_dir   <= w_buf_dir_nxt;
            r_rom_oe_n  <= w_rom_oe_n_nxt;
            r_dtack_n   <= w_dtack_n_nxt;
            r_ide_rst_n <= 1'b1;
        end
    end

    assign bus.IDE_CS_n     = r_cs_n;
    assign bus.IDE_DA       = r_da;
    assign bus.IDE_RD_n     = r_rd_n;
    assign bus.IDE_WR_n     = r_wr_n;
    assign bus.IDE_BUF_OE_n = r_buf_oe_n;
    assign bus.IDE_BUF_DIR  = r_buf_dir;
    assign bus.ROM_OE_n     = r_rom_oe_n;
    assign bus.DTACK_n      = r_dtack_n;
    assign bus.IDE_RST_n    = r_ide_rst_n;

endmodule

// File: tb/tb_ide_cycle.sv
// Scoreboard bench for ide_cycle: each claimed cycle queues its expected
// strobe/ROM/DTACK profile, which a negedge monitor pops when the cycle ends.
module tb_ide_cycle;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ide_if bus ();

    ide_cycle #(
        .STROBE_CYCLES(2),
        .IORDY_TIMEOUT(16),
        .ROM_WAIT(1)
    ) dut (
        .C7M(clk),
        .RESET_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        string      tag;
        logic [1:0] cs_n;
        logic [2:0] da;
        logic       dir;
        int         rd_len;
        int         wr_len;
        int         rom_pre;
        bit         rom_any;
        int         dtack_at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    // {CS_n, DA, RD_n, WR_n, BUF_OE_n, BUF_DIR, ROM_OE_n, DTACK_n, IDE_RST_n}
    localparam logic [11:0] OUT_RST  = 12'b11_000_1_1_1_0_1_1_0;
    localparam logic [11:0] OUT_IDLE = 12'b11_000_1_1_1_0_1_1_1;
    localparam logic [11:0] DIR_MASK = 12'h008;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.IDE_CS_n, bus.IDE_DA, bus.IDE_RD_n, bus.IDE_WR_n, bus.IDE_BUF_OE_n,
                bus.IDE_BUF_DIR, bus.ROM_OE_n, bus.DTACK_n, bus.IDE_RST_n};
    endfunction

    function automatic exp_t mk(input string tag, input logic [1:0] cs_n, input logic [2:0] da,
                                input logic dir, input int rd_len, input int wr_len,
                                input int rom_pre, input bit rom_any, input int dtack_at);
        exp_t e;
        e.tag = tag; e.cs_n = cs_n; e.da = da; e.dir = dir;
        e.rd_len = rd_len; e.wr_len = wr_len; e.rom_pre = rom_pre;
        e.rom_any = rom_any; e.dtack_at = dtack_at;
        return e;
    endfunction

    // Monitor: one observation per contiguous stretch of non-idle outputs
    bit         in_txn = 1'b0;
    bit         got_cs;
    bit         o_rom_any;
    int         idx, o_rd, o_wr, o_rom, o_dt;
    logic [1:0] o_cs;
    logic [2:0] o_da;
    logic       o_dir;
    exp_t       me;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            in_txn = 1'b0;
        end else if ((bus.IDE_CS_n != 2'b11) || !bus.ROM_OE_n || !bus.DTACK_n ||
                     !bus.IDE_BUF_OE_n || !bus.IDE_RD_n || !bus.IDE_WR_n) begin
            if (!in_txn) begin
                in_txn = 1'b1; idx = 0; o_rd = 0; o_wr = 0; o_rom = 0; o_dt = -1;
                got_cs = 1'b0; o_rom_any = 1'b0; o_cs = 2'b11; o_da = 3'd0; o_dir = 1'b0;
            end
            if (!got_cs && (bus.IDE_CS_n != 2'b11)) begin
                got_cs = 1'b1; o_cs = bus.IDE_CS_n; o_da = bus.IDE_DA; o_dir = bus.IDE_BUF_DIR;
            end
            if (!bus.IDE_RD_n) o_rd++;
            if (!bus.IDE_WR_n) o_wr++;
            if (!bus.ROM_OE_n) o_rom_any = 1'b1;
            if (!bus.ROM_OE_n && bus.DTACK_n) o_rom++;
            if (!bus.DTACK_n && (o_dt < 0)) o_dt = idx;
            idx++;
        end else if (in_txn) begin
            in_txn = 1'b0;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                me = exp_q.pop_front();
                check({me.tag, "_cs"},       32'(o_cs),      32'(me.cs_n));
                check({me.tag, "_da"},       32'(o_da),      32'(me.da));
                check({me.tag, "_dir"},      32'(o_dir),     32'(me.dir));
                check({me.tag, "_rd_len"},   32'(o_rd),      32'(me.rd_len));
                check({me.tag, "_wr_len"},   32'(o_wr),      32'(me.wr_len));
                check({me.tag, "_rom_pre"},  32'(o_rom),     32'(me.rom_pre));
                check({me.tag, "_rom_any"},  32'(o_rom_any), 32'(me.rom_any));
                check({me.tag, "_dtack_at"}, 32'(o_dt),      32'(me.dtack_at));
            end
        end
    end

    task automatic drive_start(input logic [15:0] a, input bit rd);
        @(negedge clk);
        bus.A_HIGH   = 8'hE9;
        bus.A_MID    = a[15:11];
        bus.A_REG    = a[10:9];
        bus.RW_n     = rd;
        bus.AS_CPU_n = 1'b0;
        bus.DS_n     = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        for (int n = 0; n < 40 && bus.IDE_RD_n && bus.IDE_WR_n; n++) @(negedge clk);
        if (bus.IDE_RD_n && bus.IDE_WR_n) check({tag, "_stb_timeout"}, 32'd1, 32'd0);
    endtask

    // iordy_low: 0 = ready, >0 = released that many strobe cycles in, -1 = never
    task automatic bus_cycle(input exp_t e, input logic [15:0] a, input bit rd,
                             input int iordy_low, input bit abort);
        int k;
        bus.IORDY = (iordy_low == 0);
        drive_start(a, rd);
        exp_q.push_back(e);
        if (abort) begin
            wait_strobe(e.tag);
            bus.AS_CPU_n = 1'b1;
            bus.DS_n     = 1'b1;
            for (k = 1; k <= 6; k++) begin
                @(posedge clk); #1;
                if ((bus.IDE_CS_n == 2'b11) && bus.IDE_BUF_OE_n && bus.IDE_RD_n && bus.IDE_WR_n) break;
            end
            check({e.tag, "_release"}, 32'(k <= 3), 32'd1);
            bus.IORDY = 1'b1;
            repeat (3) @(negedge clk);
            return;
        end
        if (iordy_low > 0) begin
            wait_strobe(e.tag);
            repeat (iordy_low - 1) @(negedge clk);
            bus.IORDY = 1'b1;
        end
        for (int n = 0; n < 60 && bus.DTACK_n; n++) @(negedge clk);
        if (bus.DTACK_n) check({e.tag, "_dtack_timeout"}, 32'd1, 32'd0);
        bus.IORDY    = 1'b1;
        bus.AS_CPU_n = 1'b1;
        bus.DS_n     = 1'b1;
        // capture edge plus two synchroniser edges
        for (k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (bus.DTACK_n) break;
        end
        check({e.tag, "_dtack_rel"}, 32'(k), 32'd3);
        repeat (2) @(negedge clk);
    endtask

    task automatic ignore_cycle(input string tag, input logic [15:0] a);
        drive_start(a, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check(tag, 32'(outs() & ~DIR_MASK), 32'(OUT_IDLE & ~DIR_MASK));
        end
        bus.AS_CPU_n = 1'b1;
        bus.DS_n     = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AS_CPU_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1;
        bus.A_HIGH = 8'h00; bus.A_MID = 5'd0; bus.A_REG = 2'd0;
        bus.BASE_IDE = 8'hE9; bus.IDE_CONFIGURED_n = 1'b0;
        bus.ROM_EN = 1'b1; bus.IORDY = 1'b1;

        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(outs()), 32'(OUT_RST));
        repeat (3) @(posedge clk);
        #1 check("rst_hold", 32'(outs()), 32'(OUT_RST));
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_ide_low", 32'(bus.IDE_RST_n), 32'd0);
        @(posedge clk); #1 check("rst_ide_rise", 32'(bus.IDE_RST_n), 32'd1);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        bus_cycle(mk("stat_rd",  2'b10, 3'd7, 1'b1, 2, 0,  0, 1'b0, 4),  16'h8E00, 1'b1, 0,  1'b0);
        bus_cycle(mk("data_rd",  2'b10, 3'd6, 1'b1, 2, 0,  0, 1'b0, 4),  16'h8C00, 1'b1, 0,  1'b0);
        bus_cycle(mk("wr_plain", 2'b01, 3'd1, 1'b0, 0, 2,  0, 1'b0, 4),  16'h9200, 1'b0, 0,  1'b0);
        bus_cycle(mk("wr_ior5",  2'b01, 3'd1, 1'b0, 0, 7,  0, 1'b0, 9),  16'h9200, 1'b0, 5,  1'b0);
        bus_cycle(mk("wr_iorto", 2'b01, 3'd1, 1'b0, 0, 18, 0, 1'b0, 20), 16'h9200, 1'b0, -1, 1'b0);

        bus.ROM_EN = 1'b1;
        bus_cycle(mk("rom_rd",   2'b11, 3'd0, 1'b0, 0, 0,  1, 1'b1, 1),  16'h0010, 1'b1, 0,  1'b0);
        bus_cycle(mk("rom_wr",   2'b11, 3'd0, 1'b0, 0, 0,  0, 1'b0, 0),  16'h0010, 1'b0, 0,  1'b0);
        bus.ROM_EN = 1'b0;
        bus_cycle(mk("rom_dis",  2'b11, 3'd0, 1'b0, 0, 0,  0, 1'b0, 0),  16'h0010, 1'b1, 0,  1'b0);
        bus.ROM_EN = 1'b1;

        bus.IDE_CONFIGURED_n = 1'b1;
        ignore_cycle("ign_unconf", 16'h8E00);
        bus.IDE_CONFIGURED_n = 1'b0;
        bus.BASE_IDE = 8'hE8;
        ignore_cycle("ign_base", 16'h8E00);
        bus.BASE_IDE = 8'hE9;

        bus_cycle(mk("abort",      2'b10, 3'd7, 1'b1, 3, 0, 0, 1'b0, -1), 16'h8E00, 1'b1, -1, 1'b1);
        bus_cycle(mk("post_abort", 2'b10, 3'd7, 1'b1, 2, 0, 0, 1'b0, 4),  16'h8E00, 1'b1, 0,  1'b0);

        // Reset during STROBE: outputs must snap to reset values with no clock edge
        mon_en = 1'b0;
        bus.IORDY = 1'b0;
        drive_start(16'h8E00, 1'b1);
        wait_strobe("mid_rst");
        #2 rst_n = 1'b0;
        #1 check("mid_rst_outs", 32'(outs()), 32'(OUT_RST));
        bus.AS_CPU_n = 1'b1; bus.DS_n = 1'b1; bus.IORDY = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        #1 check("mid_rst_ide_low", 32'(bus.IDE_RST_n), 32'd0);
        @(posedge clk); #1 check("mid_rst_ide_rise", 32'(bus.IDE_RST_n), 32'd1);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        bus_cycle(mk("post_rst", 2'b01, 3'd1, 1'b1, 2, 0, 0, 1'b0, 4), 16'h9200, 1'b1, 0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
